// File: rtl/disp_pkg.sv
// Shared definitions for the MAX7219 display controller.
//   - MAX7219 register addresses
//   - Code-B blank nibble
//   - Controller FSM state type
//   - Packet builder: address in [15:8], data in [7:0]
package disp_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_DISPTEST  = 8'h0F;

  // Code-B value that drives a digit dark.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {INIT, IDLE, UPD} disp_state_t;

  function automatic logic [15:0] mk_pkt(input logic [7:0] addr, input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/max7219_ctrl_if.sv
// Handshake bundle between the display controller, its value source and the
// downstream 16-bit SPI packet sender.
//   val/val_vld/val_rdy : BCD value input handshake (nibble 0 = least-significant digit)
//   pkt/pkt_vld/pkt_rdy : packet output handshake
//   busy                : init or update in progress
// Modports: master = controller side, slave = source/sender side.
interface max7219_ctrl_if #(
  parameter int unsigned DIGITS = 4
);

  logic [4*DIGITS-1:0] val;
  logic                val_vld;
  logic                val_rdy;
  logic [15:0]         pkt;
  logic                pkt_vld;
  logic                pkt_rdy;
  logic                busy;

  modport master (
    input  val, val_vld, pkt_rdy,
    output val_rdy, pkt, pkt_vld, busy
  );

  modport slave (
    output val, val_vld, pkt_rdy,
    input  val_rdy, pkt, pkt_vld, busy
  );

endinterface

// File: rtl/max7219_ctrl.sv
// MAX7219 display controller.
// After reset it sends the five-packet init sequence (shutdown off, display test
// off, scan limit, decode all, intensity), then idles. Each accepted BCD value is
// latched and written out as one digit-register packet per digit, digit 0 first.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high (shared with the downstream sender)
//   bus  : max7219_ctrl_if.master (val/val_vld/val_rdy, pkt/pkt_vld/pkt_rdy, busy)
// Parameters:
//   DIGITS    : displayed digits, 1..8
//   INTENSITY : brightness nibble for register 0x0A
// Build option: define DISP_LZ_BLANK_EN for leading-zero blanking (digit 0 never blanked).
module max7219_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input logic             clk,
  input logic             rst,
  max7219_ctrl_if.master  bus
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam logic [2:0] INIT_LAST = 3'd4;
  localparam logic [2:0] UPD_LAST  = 3'(DIGITS - 1);

  disp_state_t   state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [VW-1:0] val_q, val_d;
  logic [15:0]   pkt_q, pkt_d;
  logic          pkt_vld_q, pkt_vld_d;
  logic          val_rdy_q, val_rdy_d;
  logic          busy_q, busy_d;

  logic [31:0]   val_pad;
  logic [3:0]    digit;
  logic [7:0]    digit_data;
  logic [15:0]   init_pkt;
  logic [15:0]   upd_pkt;
  logic [2:0]    last_idx;

  // Padding to the 8-digit maximum keeps the digit select index exactly sized.
  assign val_pad = 32'(val_q);
  assign digit   = val_pad[{idx_q, 2'b00} +: 4];

`ifdef DISP_LZ_BLANK_EN
  logic [7:0] blank_mask;

  // Bit d set when nibble d and every nibble above it are zero; digit 0 excluded.
  function automatic logic [7:0] lz_mask(input logic [31:0] v);
    logic [7:0] m;
    logic       zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
      zero_above = zero_above && (v[4*d +: 4] == 4'h0);
      m[d]       = zero_above;
    end
    return m;
  endfunction

  assign blank_mask = lz_mask(val_pad);
  assign digit_data = {4'h0, blank_mask[idx_q] ? BCD_BLANK : digit};
`else
  assign digit_data = {4'h0, digit};
`endif

  assign upd_pkt = mk_pkt(REG_DIGIT0 + 8'(idx_q), digit_data);

  always_comb begin
    init_pkt = mk_pkt(REG_INTENSITY, {4'h0, INTENSITY});
    unique case (idx_q)
      3'd0:    init_pkt = mk_pkt(REG_SHUTDOWN, 8'h01);
      3'd1:    init_pkt = mk_pkt(REG_DISPTEST, 8'h00);
      3'd2:    init_pkt = mk_pkt(REG_SCANLIM, 8'(DIGITS - 1));
      3'd3:    init_pkt = mk_pkt(REG_DECODE, 8'hFF);
      default: init_pkt = mk_pkt(REG_INTENSITY, {4'h0, INTENSITY});
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    val_d     = val_q;
    pkt_d     = pkt_q;
    pkt_vld_d = pkt_vld_q;
    val_rdy_d = val_rdy_q;
    busy_d    = busy_q;
    last_idx  = (state_q == INIT) ? INIT_LAST : UPD_LAST;

    unique case (state_q)
      INIT, UPD: begin
        if (!pkt_vld_q) begin
          // Load during the gap cycle so pkt never changes while pkt_vld is high.
          pkt_d     = (state_q == INIT) ? init_pkt : upd_pkt;
          pkt_vld_d = 1'b1;
        end else if (bus.pkt_rdy) begin
          pkt_vld_d = 1'b0;
          if (idx_q == last_idx) begin
            state_d   = IDLE;
            idx_d     = '0;
            val_rdy_d = 1'b1;
            busy_d    = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      IDLE: begin
        if (bus.val_vld && val_rdy_q) begin
          val_d     = bus.val;
          idx_d     = '0;
          state_d   = UPD;
          val_rdy_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      idx_q     <= '0;
      val_q     <= '0;
      pkt_q     <= 16'h0000;
      pkt_vld_q <= 1'b0;
      val_rdy_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      pkt_q     <= pkt_d;
      pkt_vld_q <= pkt_vld_d;
      val_rdy_q <= val_rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.pkt     = pkt_q;
  assign bus.pkt_vld = pkt_vld_q;
  assign bus.val_rdy = val_rdy_q;
  assign bus.busy    = busy_q;

endmodule
